uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial UART receiver. Converts the 1-start / 8-data (LSB first) / 1-stop frame produced by the existing transmitter chain back into parallel bytes.
- Sits on the receive side of the link, clocked by the same system clock as the transmitter side.
- Synchronises the asynchronous RX line, validates the start bit mid-bit, samples each bit at its centre, and checks the stop bit.

Parameters:
- CLKS_PER_BIT, 16, clocks per serial bit. Must be even and >= 4.
- DATA_BITS, 8, data bits per frame, 5..8.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset. 0 = reset.
- RX  input  1  serial line, idle high, asynchronous to clk.
- data  output  DATA_BITS  last correctly received byte.
- valid  output  1  one-cycle pulse when data is updated.
- frame_err  output  1  one-cycle pulse on bad stop bit (or bad parity if enabled).
- busy  output  1  high while a frame is being received (any state except IDLE).

Behaviour:
- Reset (reset=0, asynchronous):
  - data=0, valid=0, frame_err=0, busy=0.
  - Both synchroniser flops = 1; state=IDLE; bit counter and clock counter = 0.
- Synchroniser: RX passes through 2 flops to give rx_s. All decisions use rx_s, which adds 2 cycles of latency.
- Clock counter cnt: width $clog2(CLKS_PER_BIT). Cleared on every state change. HALF = CLKS_PER_BIT/2.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - rx_s==0 -> START, cnt=0.
- START:
  - cnt counts up. At cnt==HALF-1, sample rx_s.
  - rx_s==0 -> DATA, cnt=0, bit index=0.
  - rx_s==1 -> glitch; return to IDLE with no pulse.
- DATA:
  - At cnt==CLKS_PER_BIT-1, sample rx_s into shift register bit[index], LSB first. Then index++ and cnt=0.
  - After DATA_BITS samples -> STOP.
- STOP:
  - At cnt==CLKS_PER_BIT-1, sample rx_s.
  - rx_s==1 -> data<=shift register, valid=1 for exactly one cycle, -> IDLE.
  - rx_s==0 -> frame_err=1 for one cycle, data unchanged, -> BREAK.
- BREAK: wait for rx_s==1, then -> IDLE. This prevents a held-low line from being decoded as repeated 0x00 frames.
- Timing:
  - valid/frame_err fire in the cycle after the stop sample.
  - The stop sample is taken at 2 + HALF + (DATA_BITS+1)*CLKS_PER_BIT clocks after the RX falling edge, to within ±1 clock.
- valid and frame_err are never asserted together.
- A new start bit is accepted the cycle after returning to IDLE. Back-to-back frames with no idle gap are received without loss.
- RX activity in any state other than the sample points is ignored.
- Reset asserted mid-frame aborts immediately. No pulse is generated and the partial byte is discarded.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP. It samples one bit after CLKS_PER_BIT clocks.
  - Even parity: the XOR of data bits and parity bit must be 0.
  - On mismatch, STOP is still sampled, but the frame ends with frame_err=1 instead of valid, and data is unchanged.
  - Frame length is 11 bits.
- Undefined: no PARITY state; 10-bit frame; no parity check logic is synthesised.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, RX=1 -> data=0x00, valid=0, frame_err=0, busy=0, held for 500 cycles.
- Single frame 0xA5 at 16 clk/bit: valid pulses once, 1 cycle wide, about 154 clocks after the start edge; data=0xA5; busy falls at the same time.
- Back-to-back frames 0x00, 0xFF, 0x3C with no idle gap: three valid pulses 160 clocks apart; data sequence 0x00, 0xFF, 0x3C.
- Start glitch: RX low for 4 clocks then high -> no valid, no frame_err; busy returns to 0 by clock 2+HALF+1.
- Framing error: send 0x55 with stop bit=0, then hold RX low for 300 clocks -> single frame_err pulse, data keeps its previous value, no further pulses. RX back high followed by 0x81 -> valid, data=0x81.
- Reset mid-frame: deassert reset, start 0xC3, pulse reset low during bit 4 -> outputs return to reset values immediately; the next frame 0x12 is received correctly. With UART_RX_PARITY_EN defined, 0x12 with a wrong parity bit -> frame_err, no valid.

Source files
------------

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx: serial UART receiver, 1 start / DATA_BITS data (LSB first) / 1 stop.
//
// The RX line is synchronised through two flops. A start bit is confirmed at
// its centre, each data bit is sampled at its centre, and the stop bit is
// checked before the byte is released.
//
// Optional build macro UART_RX_PARITY_EN: inserts an even-parity bit between
// the data bits and the stop bit. A parity mismatch ends the frame with
// frame_err instead of valid.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous reset, active low
//   RX         serial input, idle high, asynchronous to clk
//   data       last correctly received byte
//   valid      one-cycle pulse when data is updated
//   frame_err  one-cycle pulse on a bad stop bit (or bad parity)
//   busy       high while a frame is in progress (state other than IDLE)
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,  // even, >= 4
    parameter int DATA_BITS    = 8    // 5..8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 sync1;
    logic                 rx_s;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_bad;
    logic                 half_tick;
    logic                 bit_tick;
    logic                 frame_ok;
    logic                 frame_bad;

    assign half_tick = (cnt == CNT_HALF);
    assign bit_tick  = (cnt == CNT_LAST);

    // Two-flop synchroniser; resets to the idle-high line level so that reset
    // release never looks like a start edge.
    // NOTE: sequential logic uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, as real hardware does.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= RX;
            rx_s  <= sync1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (!rx_s) state_next = S_START;
            // A start bit that is gone by its centre is a glitch.
            S_START: if (half_tick) state_next = rx_s ? S_IDLE : S_DATA;
            S_DATA: begin
                if (bit_tick && bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                    state_next = S_PARITY;
`else
                    state_next = S_STOP;
`endif
                end
            end
            S_PARITY: if (bit_tick) state_next = S_STOP;
            // A low stop bit may be a held-low (break) line: wait for it to
            // return high rather than decoding endless 0x00 frames.
            S_STOP:  if (bit_tick) state_next = rx_s ? S_IDLE : S_BREAK;
            S_BREAK: if (rx_s) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output logic: frame verdict at the stop sample, plus busy.
    always_comb begin
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        busy      = (state != S_IDLE);
        if (state == S_STOP && bit_tick) begin
            if (rx_s && !parity_bad) frame_ok  = 1'b1;
            else                     frame_bad = 1'b1;
        end
    end

    // Datapath: bit timing, data capture and registered output pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= frame_ok;
            frame_err <= frame_bad;
            if (frame_ok) data <= shift_reg;

            // The counter restarts on every state change and after each data
            // sample; it is held at zero while waiting on the line level.
            if (state_next != state || state == S_IDLE || state == S_BREAK ||
                (state == S_DATA && bit_tick)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (state == S_START) begin
                bit_idx <= '0;
            end else if (state == S_DATA && bit_tick) begin
                shift_reg[bit_idx] <= rx_s;
                bit_idx            <= bit_idx + 1'b1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: data bits XOR parity bit must be zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_bad <= 1'b0;
        end else if (state == S_PARITY && bit_tick) begin
            parity_bad <= (^shift_reg) ^ rx_s;
        end
    end
`else
    assign parity_bad = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx: randomised self-checking bench for uart_rx.
// A monitor records every valid/frame_err pulse with its cycle number; each
// test task compares those records against frames the bench itself built.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    localparam int DB   = 8;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Valid/frame_err appear one cycle after the stop-bit centre.
    localparam int LAT = 2 + HALF + (NBITS - 1) * CPB;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          RX    = 1'b1;
    logic [DB-1:0] data;
    logic          valid;
    logic          frame_err;
    logic          busy;

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk      (clk),
        .reset    (reset),
        .RX       (RX),
        .data     (data),
        .valid    (valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int       t;
        bit       err;
        bit [7:0] d;
    } ev_t;

    ev_t evq[$];
    int  both_cnt  = 0;
    int  busy_fall = -1;
    bit  busy_prev = 1'b0;

    always @(negedge clk) begin
        if (valid === 1'b1 || frame_err === 1'b1)
            evq.push_back('{t: cyc, err: (frame_err === 1'b1), d: data});
        if (valid === 1'b1 && frame_err === 1'b1) both_cnt++;
        if (busy_prev && busy === 1'b0) busy_fall = cyc;
        busy_prev = (busy === 1'b1);
    end

    int       n_cmp = 0;
    int       n_bad = 0;
    bit [7:0] exp_data = 8'h00;  // model of the last good byte

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input bit b);
        RX = b;
        idle(CPB);
    endtask

    task automatic send_frame(input bit [7:0] b, input bit good_stop, input bit good_par);
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(good_par ? ^b : ~(^b));
`endif
        drive_bit(good_stop);
    endtask

    // Compare one recorded pulse against an expected verdict and start time.
    task automatic expect_event(input string name, input int idx, input bit err,
                                input bit [7:0] d, input int t0);
        n_cmp++;
        if (idx >= evq.size()) begin
            n_bad++;
            $display("FAIL %s: pulse %0d missing (got %0d pulses)", name, idx, evq.size());
        end else begin
            if (evq[idx].err !== err) begin
                n_bad++;
                $display("FAIL %s: pulse %0d frame_err=%0b, want %0b", name, idx, evq[idx].err, err);
            end
            n_cmp++;
            if (evq[idx].d !== d) begin
                n_bad++;
                $display("FAIL %s: pulse %0d data=%02h, want %02h", name, idx, evq[idx].d, d);
            end
            n_cmp++;
            if (evq[idx].t < t0 + LAT || evq[idx].t > t0 + LAT + 2) begin
                n_bad++;
                $display("FAIL %s: pulse %0d at +%0d clocks, want %0d..%0d", name, idx,
                         evq[idx].t - t0, LAT, LAT + 2);
            end
        end
    endtask

    task automatic expect_count(input string name, input int want);
        n_cmp++;
        if (evq.size() !== want) begin
            n_bad++;
            $display("FAIL %s: %0d pulses, want %0d", name, evq.size(), want);
        end
    endtask

    task automatic test_reset();
        int bad_cycles = 0;
        reset = 1'b0;
        RX    = 1'b1;
        idle(3);
        n_cmp++;
        if ({data, valid, frame_err, busy} !== 11'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: data=%02h valid=%b frame_err=%b busy=%b, want 00/0/0/0",
                     data, valid, frame_err, busy);
        end
        reset = 1'b1;
        evq.delete();
        for (int i = 0; i < 500; i++) begin
            idle(1);
            if (data !== 8'h00 || busy !== 1'b0) bad_cycles++;
        end
        n_cmp++;
        if (bad_cycles !== 0) begin
            n_bad++;
            $display("FAIL idle_hold: %0d cycles with data/busy not idle, want 0", bad_cycles);
        end
        expect_count("idle_pulses", 0);
    endtask

    task automatic test_single_frame();
        int t0;
        evq.delete();
        t0 = cyc;
        send_frame(8'hA5, 1'b1, 1'b1);
        idle(20);
        exp_data = 8'hA5;
        expect_count("single_count", 1);
        expect_event("single", 0, 1'b0, 8'hA5, t0);
        n_cmp++;
        if (evq.size() > 0 && busy_fall !== evq[0].t) begin
            n_bad++;
            $display("FAIL single_busy_fall: busy fell at %0d, valid at %0d", busy_fall, evq[0].t);
        end
    endtask

    task automatic test_back_to_back();
        bit [7:0] bytes[3] = '{8'h00, 8'hFF, 8'h3C};
        int       t0;
        evq.delete();
        t0 = cyc;
        for (int i = 0; i < 3; i++) send_frame(bytes[i], 1'b1, 1'b1);
        idle(20);
        expect_count("b2b_count", 3);
        for (int i = 0; i < 3; i++) expect_event("b2b", i, 1'b0, bytes[i], t0 + i * NBITS * CPB);
        exp_data = 8'h3C;
        n_cmp++;
        if (evq.size() == 3 && (evq[1].t - evq[0].t !== NBITS * CPB ||
                                evq[2].t - evq[1].t !== NBITS * CPB)) begin
            n_bad++;
            $display("FAIL b2b_spacing: %0d/%0d clocks, want %0d", evq[1].t - evq[0].t,
                     evq[2].t - evq[1].t, NBITS * CPB);
        end
    endtask

    task automatic test_glitch();
        int t0;
        evq.delete();
        busy_fall = -1;
        t0 = cyc;
        RX = 1'b0;
        idle(4);
        RX = 1'b1;
        idle(30);
        expect_count("glitch_pulses", 0);
        n_cmp++;
        if (busy_fall < 0 || busy_fall - t0 > 2 + HALF + 1) begin
            n_bad++;
            $display("FAIL glitch_busy: busy fell at +%0d, want <= %0d", busy_fall - t0, 2 + HALF + 1);
        end
    endtask

    task automatic test_frame_err();
        int t0;
        evq.delete();
        t0 = cyc;
        send_frame(8'h55, 1'b0, 1'b1);
        RX = 1'b0;
        idle(300);
        RX = 1'b1;
        idle(20);
        expect_count("ferr_count", 1);
        expect_event("ferr", 0, 1'b1, exp_data, t0);
        n_cmp++;
        if (data !== exp_data) begin
            n_bad++;
            $display("FAIL ferr_data_kept: data=%02h, want %02h", data, exp_data);
        end
        t0 = cyc;
        send_frame(8'h81, 1'b1, 1'b1);
        idle(20);
        exp_data = 8'h81;
        expect_count("ferr_recover_count", 2);
        expect_event("ferr_recover", 1, 1'b0, 8'h81, t0);
    endtask

    task automatic test_reset_mid_frame();
        bit [7:0] c3 = 8'hC3;
        int       t0;
        evq.delete();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(c3[i]);
        RX = c3[4];
        idle(HALF);
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({data, valid, frame_err, busy} !== 11'h0) begin
            n_bad++;
            $display("FAIL midreset_outputs: data=%02h valid=%b frame_err=%b busy=%b, want 00/0/0/0",
                     data, valid, frame_err, busy);
        end
        idle(3);
        RX = 1'b1;
        idle(3);
        reset = 1'b1;
        idle(5);
        exp_data = 8'h00;
        expect_count("midreset_pulses", 0);
        t0 = cyc;
        send_frame(8'h12, 1'b1, 1'b1);
        idle(20);
        exp_data = 8'h12;
        expect_count("after_reset_count", 1);
        expect_event("after_reset", 0, 1'b0, 8'h12, t0);
`ifdef UART_RX_PARITY_EN
        t0 = cyc;
        send_frame(8'h12, 1'b1, 1'b0);
        idle(20);
        expect_count("bad_parity_count", 2);
        expect_event("bad_parity", 1, 1'b1, 8'h12, t0);
`endif
    endtask

    task automatic test_random();
        ev_t exp_q[$];
        evq.delete();
        for (int n = 0; n < 24; n++) begin
            bit [7:0] b         = 8'($urandom);
            bit       good_stop = ($urandom_range(0, 4) != 0);
            bit       good_par  = 1'b1;
            bit       err;
            int       t0;
`ifdef UART_RX_PARITY_EN
            good_par = ($urandom_range(0, 4) != 0);
`endif
            err = !good_stop || !good_par;
            t0  = cyc;
            if (!err) exp_data = b;
            exp_q.push_back('{t: t0, err: err, d: exp_data});
            send_frame(b, good_stop, good_par);
            if (!good_stop) begin
                RX = 1'b0;
                idle($urandom_range(0, 40));
                RX = 1'b1;
                idle(4);
            end
            if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 40));
        end
        idle(20);
        expect_count("rand_count", exp_q.size());
        foreach (exp_q[i]) expect_event("rand", i, exp_q[i].err, exp_q[i].d, exp_q[i].t);
        n_cmp++;
        if (both_cnt !== 0) begin
            n_bad++;
            $display("FAIL exclusive_pulses: %0d cycles with valid and frame_err, want 0", both_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
